// File: rtl/dmi_arb_pkg.sv
// Shared types for the DMI arbiter: the DMI request/response structs, FSM states,
// the default DM wait limit and the owner-index width helper.
package dmi_arb_pkg;

   // DMI request/response layout; must stay bit-compatible with the Debug Module's types.
   typedef enum logic [1:0] {
      DTM_NOP   = 2'h0,
      DTM_READ  = 2'h1,
      DTM_WRITE = 2'h2
   } dtm_op_e;

   localparam logic [1:0] DTM_ERR = 2'h2;

   typedef struct packed {
      logic [6:0]  addr;
      dtm_op_e     op;
      logic [31:0] data;
   } dmi_req_t;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
   } dmi_resp_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FWD,
      ST_WAIT,
      ST_RET
   } arb_state_e;

   localparam int unsigned DMI_ARB_TIMEOUT_DEFAULT = 1024;

   function automatic int unsigned owner_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dmi_arbiter_rr.sv
// Combinational round-robin pick: first valid requester after last_i, wrapping.
module rr_arbiter
   import dmi_arb_pkg::*;
#(
   parameter int unsigned  N_REQ = 2,
   localparam int unsigned OW    = owner_width(N_REQ)
) (
   input  logic [N_REQ-1:0] valid_i,
   input  logic [OW-1:0]    last_i,
   output logic             gnt_valid_o,
   output logic [OW-1:0]    gnt_idx_o
);

   int idx;

   always_comb begin
      gnt_valid_o = 1'b0;
      gnt_idx_o   = '0;
      idx         = 0;
      for (int k = 1; k <= int'(N_REQ); k++) begin
         idx = int'(last_i) + k;
         if (idx >= int'(N_REQ)) idx = idx - int'(N_REQ);
         if (!gnt_valid_o && valid_i[OW'(idx)]) begin
            gnt_valid_o = 1'b1;
            gnt_idx_o   = OW'(idx);
         end
      end
   end

endmodule

// File: rtl/dmi_arbiter.sv
// Round-robin arbiter sharing one DM DMI port among N_REQ requesters, one transaction
// in flight. Optional DM hang recovery is enabled by defining DMI_ARB_TIMEOUT_EN.
module dmi_arbiter
   import dmi_arb_pkg::*;
#(
   parameter int unsigned  N_REQ          = 2,
   parameter int unsigned  TIMEOUT_CYCLES = DMI_ARB_TIMEOUT_DEFAULT,
   localparam int unsigned OW             = owner_width(N_REQ)
) (
   input  logic                              CLK_I,
   input  logic                              RST_I,
   input  logic [N_REQ-1:0]                  REQ_VALID_I,
   output logic [N_REQ-1:0]                  REQ_READY_O,
   input  logic [N_REQ*$bits(dmi_req_t)-1:0] REQ_I,
   output logic [N_REQ-1:0]                  RESP_VALID_O,
   input  logic [N_REQ-1:0]                  RESP_READY_I,
   output logic [$bits(dmi_resp_t)-1:0]      RESP_O,
   output logic                              DM_REQ_VALID_O,
   input  logic                              DM_REQ_READY_I,
   output logic [$bits(dmi_req_t)-1:0]       DM_REQ_O,
   input  logic                              DM_RESP_VALID_I,
   output logic                              DM_RESP_READY_O,
   input  logic [$bits(dmi_resp_t)-1:0]      DM_RESP_I,
   output logic                              BUSY_O,
   output logic [OW-1:0]                     OWNER_O
);

   localparam int unsigned REQ_W = $bits(dmi_req_t);

   if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
      $error("dmi_arbiter: N_REQ must be in 2..8");
   end
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("dmi_arbiter: TIMEOUT_CYCLES must be at least 2");
   end

   arb_state_e state_q, state_d;
   logic [OW-1:0] owner_q, owner_d;
   logic [OW-1:0] last_q, last_d;
   dmi_req_t  req_q, req_d;
   dmi_resp_t resp_q, resp_d;
   dmi_req_t  req_arr [N_REQ];
   logic          gnt_valid;
   logic [OW-1:0] gnt_idx;
   logic          stale;
   logic          timeout;

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign req_arr[gi] = dmi_req_t'(REQ_I[gi*REQ_W +: REQ_W]);
   end

   rr_arbiter #(.N_REQ(N_REQ)) u_rr (
      .valid_i     (REQ_VALID_I),
      .last_i      (last_q),
      .gnt_valid_o (gnt_valid),
      .gnt_idx_o   (gnt_idx)
   );

`ifdef DMI_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             stale_q, stale_d;

   assign stale   = stale_q;
   assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign stale   = 1'b0;
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d         = state_q;
      owner_d         = owner_q;
      last_d          = last_q;
      req_d           = req_q;
      resp_d          = resp_q;
      REQ_READY_O     = '0;
      RESP_VALID_O    = '0;
      DM_REQ_VALID_O  = 1'b0;
      DM_RESP_READY_O = stale;
`ifdef DMI_ARB_TIMEOUT_EN
      stale_d = stale_q;
      // A late answer to a timed-out request is swallowed here, never forwarded.
      if (stale_q && DM_RESP_VALID_I) stale_d = 1'b0;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (gnt_valid && !stale && !RST_I) begin
               REQ_READY_O[gnt_idx] = 1'b1;
               req_d   = req_arr[gnt_idx];
               owner_d = gnt_idx;
               last_d  = gnt_idx;
               state_d = ST_FWD;
            end
         end
         ST_FWD: begin
            DM_REQ_VALID_O = 1'b1;
            if (DM_REQ_READY_I) begin
               state_d = ST_WAIT;
            end else if (timeout) begin
               resp_d  = dmi_resp_t'{data: 32'h0, resp: DTM_ERR};
               state_d = ST_RET;
            end
         end
         ST_WAIT: begin
            DM_RESP_READY_O = 1'b1;
            if (DM_RESP_VALID_I) begin
               resp_d  = dmi_resp_t'(DM_RESP_I);
               state_d = ST_RET;
            end else if (timeout) begin
               resp_d  = dmi_resp_t'{data: 32'h0, resp: DTM_ERR};
               state_d = ST_RET;
`ifdef DMI_ARB_TIMEOUT_EN
               stale_d = 1'b1;
`endif
            end
         end
         ST_RET: begin
            RESP_VALID_O[owner_q] = 1'b1;
            if (RESP_READY_I[owner_q]) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
`ifdef DMI_ARB_TIMEOUT_EN
      if ((state_d == ST_FWD && state_q != ST_FWD) ||
          (state_q == ST_FWD && state_d == ST_WAIT)) begin
         cnt_d = '0;
      end else if (state_q == ST_FWD || state_q == ST_WAIT) begin
         cnt_d = cnt_q + 1'b1;
      end else begin
         cnt_d = cnt_q;
      end
`endif
   end

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         state_q <= ST_IDLE;
         owner_q <= '0;
         last_q  <= OW'(N_REQ - 1);
         req_q   <= '0;
         resp_q  <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         req_q   <= req_d;
         resp_q  <= resp_d;
      end
   end

`ifdef DMI_ARB_TIMEOUT_EN
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         cnt_q   <= '0;
         stale_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         stale_q <= stale_d;
      end
   end
`endif

   assign DM_REQ_O = req_q;
   assign RESP_O   = resp_q;
   assign BUSY_O   = (state_q != ST_IDLE);
   assign OWNER_O  = owner_q;

endmodule
